fft_stage1_seq: RTL and testbench

Control sequencer for the 32-point MDC FFT first stage (commutator, 16-deep delay line, radix-2 butterfly, 16-entry twiddle ROM and multiplier). It tracks the position of each incoming sample pair within a 32-sample frame. It drives the stage's commutator mode, butterfly mode, multiplier mode, state code and twiddle ROM index. It also flags output validity and framing errors to the next stage.

---
 rtl/fft_stage1_seq.sv | 164 ++++++++++++++++
 tb/tb_fft_stage1_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fft_stage1_seq.sv
// Control sequencer for the 32-point MDC FFT first stage: tracks sample position within a
// frame and drives registered commutator/butterfly/multiplier/twiddle controls one cycle later.
module fft_stage1_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic       clr_err,
    output logic [4:0] state_com_mode,
    output logic       butter_mode,
    output logic       mul_mode,
    output logic [6:0] state_code,
    output logic [3:0] rom_16_counter,
    output logic       out_valid,
    output logic       out_sof,
    output logic       frame_done,
    output logic       busy,
    output logic [1:0] err
);

    localparam int unsigned FRAME_LEN = 32;
    localparam int unsigned HALF_LEN  = 16;
    localparam int unsigned POS_W     = 5;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned ROM_W     = 4;
    localparam int unsigned MODE_W    = 5;
    localparam int unsigned CODE_W    = CNT_W + POS_W;

    localparam logic [MODE_W-1:0] MODE_FILL    = 5'b00001;
    localparam logic [MODE_W-1:0] MODE_COMPUTE = 5'b00010;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   p_exp_q, p_exp_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [1:0]         err_q, err_d, err_new;
    logic               acc;
    logic [POS_W-1:0]   acc_pos;

    logic [MODE_W-1:0]  com_q, com_d;
    logic               bm_q, bm_d;
    logic               mm_q, mm_d;
    logic [CODE_W-1:0]  sc_q, sc_d;
    logic [ROM_W-1:0]   rom_q, rom_d;
    logic               ov_q, ov_d;
    logic               osof_q, osof_d;
    logic               fd_q, fd_d;

    // Frame tracking, error detection and decode of the accepted sample for the next cycle.
    always_comb begin
        state_d     = state_q;
        p_exp_d     = p_exp_q;
        frame_cnt_d = frame_cnt_q;
        err_new     = '0;
        acc         = 1'b0;
        acc_pos     = '0;
        com_d       = '0;
        bm_d        = 1'b0;
        mm_d        = 1'b0;
        sc_d        = sc_q;
        rom_d       = '0;
        ov_d        = 1'b0;
        osof_d      = 1'b0;
        fd_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_sof) begin
                    acc     = 1'b1;
                    state_d = ACTIVE;
                    p_exp_d = POS_W'(1);
                end
            end
            ACTIVE: begin
                if (p_exp_q != '0) begin
                    if (!in_valid) begin
                        err_new[0] = 1'b1;
                        state_d    = IDLE;
                        p_exp_d    = '0;
                    end else if (in_sof) begin
                        err_new[1] = 1'b1;
                        acc        = 1'b1;
                        p_exp_d    = POS_W'(1);
                    end else begin
                        acc     = 1'b1;
                        acc_pos = p_exp_q;
                        p_exp_d = p_exp_q + POS_W'(1);
                    end
                end else begin
                    // Frame boundary: only a fresh in_sof keeps the sequencer running.
                    if (in_valid && in_sof) begin
                        acc     = 1'b1;
                        p_exp_d = POS_W'(1);
                    end else begin
                        state_d = IDLE;
                        if (in_valid) err_new[1] = 1'b1;
                    end
                end
            end
        endcase

        if (acc && (acc_pos == POS_W'(FRAME_LEN - 1))) frame_cnt_d = frame_cnt_q + CNT_W'(1);

        err_d = (clr_err ? 2'b00 : err_q) | err_new;

        if (acc) begin
            sc_d = {frame_cnt_q, acc_pos};
            if (acc_pos >= POS_W'(HALF_LEN)) begin
                com_d  = MODE_COMPUTE;
                bm_d   = 1'b1;
                rom_d  = acc_pos[ROM_W-1:0];
                mm_d   = (acc_pos[ROM_W-1:0] != '0);
                ov_d   = 1'b1;
                osof_d = (acc_pos == POS_W'(HALF_LEN));
                fd_d   = (acc_pos == POS_W'(FRAME_LEN - 1));
            end else begin
                com_d = MODE_FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            p_exp_q     <= '0;
            frame_cnt_q <= '0;
            err_q       <= '0;
            com_q       <= '0;
            bm_q        <= 1'b0;
            mm_q        <= 1'b0;
            sc_q        <= '0;
            rom_q       <= '0;
            ov_q        <= 1'b0;
            osof_q      <= 1'b0;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_exp_q     <= p_exp_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            com_q       <= com_d;
            bm_q        <= bm_d;
            mm_q        <= mm_d;
            sc_q        <= sc_d;
            rom_q       <= rom_d;
            ov_q        <= ov_d;
            osof_q      <= osof_d;
            fd_q        <= fd_d;
        end
    end

    assign state_com_mode = com_q;
    assign butter_mode    = bm_q;
    assign mul_mode       = mm_q;
    assign state_code     = sc_q;
    assign rom_16_counter = rom_q;
    assign out_valid      = ov_q;
    assign out_sof        = osof_q;
    assign frame_done     = fd_q;
    assign busy           = (state_q == ACTIVE);
    assign err            = err_q;

endmodule

// File: tb/tb_fft_stage1_seq.sv
// Directed vector bench for fft_stage1_seq: a table of per-cycle inputs and expected controls,
// plus hand-written reset and restart sequences.
module tb_fft_stage1_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_sof, clr_err;
    logic [4:0] state_com_mode;
    logic       butter_mode, mul_mode;
    logic [6:0] state_code;
    logic [3:0] rom_16_counter;
    logic       out_valid, out_sof, frame_done, busy;
    logic [1:0] err;

    fft_stage1_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_sof         (in_sof),
        .clr_err        (clr_err),
        .state_com_mode (state_com_mode),
        .butter_mode    (butter_mode),
        .mul_mode       (mul_mode),
        .state_code     (state_code),
        .rom_16_counter (rom_16_counter),
        .out_valid      (out_valid),
        .out_sof        (out_sof),
        .frame_done     (frame_done),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Expected bus layout: {com[4:0], bm, mm, sc[6:0], rom[3:0], ov, osof, fd, busy, err[1:0]}
    typedef struct {
        logic        v;
        logic        s;
        logic        c;
        logic [23:0] exp;
        string       name;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] last_sc = '0;
    int         n_vec   = 0;
    int         n_fail  = 0;

    function automatic logic [23:0] actual();
        return {state_com_mode, butter_mode, mul_mode, state_code, rom_16_counter,
                out_valid, out_sof, frame_done, busy, err};
    endfunction

    // A sample accepted at position p in frame fc.
    task automatic add_acc(input logic sof, input int p, input int fc, input logic [1:0] e,
                           input string nm);
        vec_t        r;
        logic [4:0]  pos;
        logic [1:0]  f;
        logic [3:0]  lo;
        pos = 5'(p);
        f   = 2'(fc);
        lo  = pos[3:0];
        r.v = 1'b1; r.s = sof; r.c = 1'b0; r.name = nm;
        if (p >= 16)
            r.exp = {5'b00010, 1'b1, (lo != 4'd0), f, pos, lo,
                     1'b1, (p == 16), (p == 31), 1'b1, e};
        else
            r.exp = {5'b00001, 1'b0, 1'b0, f, pos, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, e};
        last_sc = {f, pos};
        vecs.push_back(r);
    endtask

    // A cycle with no acceptance: controls zero, state_code holds.
    task automatic add_idle(input logic v, input logic s, input logic c, input logic b,
                            input logic [1:0] e, input string nm);
        vec_t r;
        r.v = v; r.s = s; r.c = c; r.name = nm;
        r.exp = {5'b0, 1'b0, 1'b0, last_sc, 4'd0, 1'b0, 1'b0, 1'b0, b, e};
        vecs.push_back(r);
    endtask

    task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic c);
        in_valid = v; in_sof = s; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; clr_err = 1'b0;

        // Three back-to-back frames, then a quiet cycle at the frame boundary.
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < 32; p++)
                add_acc(p == 0, p, f, 2'b00, $sformatf("bb_f%0d_p%0d", f, p));
        add_idle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, "end_idle");

        // Gap at position 20 abandons the frame.
        for (int p = 0; p < 20; p++) add_acc(p == 0, p, 3, 2'b00, $sformatf("gap_p%0d", p));
        add_idle(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, "gap_err");

        // Restart, then in_sof at position 9 resyncs to 0 and the frame completes.
        for (int p = 0; p < 9; p++) add_acc(p == 0, p, 3, 2'b01, $sformatf("rs_p%0d", p));
        add_acc(1'b1, 0, 3, 2'b11, "resync");
        for (int p = 1; p < 32; p++) add_acc(1'b0, p, 3, 2'b11, $sformatf("rs2_p%0d", p));
        add_idle(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, "rs_end");

        // Error clearing, including clr_err colliding with a new gap error.
        add_idle(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, "clr1");
        add_idle(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, "clr_none");
        for (int p = 0; p < 5; p++) add_acc(p == 0, p, 0, 2'b00, $sformatf("cg_p%0d", p));
        add_idle(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, "clr_vs_gap");
        add_idle(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, "clr2");
        add_idle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "idle_nosof");

        // Complete frame followed by a valid sample without in_sof at the boundary.
        for (int p = 0; p < 32; p++) add_acc(p == 0, p, 0, 2'b00, $sformatf("bd_p%0d", p));
        add_idle(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, "bd_nosof");

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", actual(), 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_release", actual(), 24'h0);

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].s, vecs[i].c);
            check(vecs[i].name, actual(), vecs[i].exp);
        end

        // Reset asserted mid-frame at position 25 (frame_cnt is 1 at this point).
        step(1'b0, 1'b0, 1'b1);
        for (int p = 0; p < 26; p++) step(1'b1, p == 0, 1'b0);
        check("pre_rst_p25", actual(),
              {5'b00010, 1'b1, 1'b1, 7'b01_11001, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", actual(), 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("post_rst_nosof%0d", k), actual(), 24'h0);
        end
        step(1'b1, 1'b1, 1'b0);
        check("post_rst_sof", actual(),
              {5'b00001, 1'b0, 1'b0, 7'b00_00000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
